// File: rtl/cache_pkg.sv
// Shared definitions for the stage-4 direct-mapped cache controller:
// memory opcodes and the controller state encoding.
package cache_pkg;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cache_array.sv
// Direct-mapped tag/valid/data storage with a combinational lookup port
// and a single registered write port shared by refill and store updates.
module cache_array
  import cache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LINES = 4,
  parameter int WORDS = 4,
  parameter int TAG_W = 1,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [WIDTH-1:0] rd_word,
  input  logic             word_we,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [WIDTH-1:0] wr_word,
  input  logic             line_inval,
  input  logic             line_fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             flush_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [WIDTH-1:0] data_q [LINES*WORDS];

  // Only the valid bits are reset; tags and data are meaningless while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (line_fill) begin
      valid_q[wr_index] <= 1'b1;
    end else if (line_inval) begin
      valid_q[wr_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_q[wr_index] <= fill_tag;
    end
    if (word_we) begin
      data_q[{wr_index, wr_offset}] <= wr_word;
    end
  end

  assign hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_word = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/fsm_step_4_cache_ctrl.sv
// Stage-4 load/store cache controller: direct-mapped, write-through,
// no write-allocate, full-line refill one word per memory ack.
module fsm_step_4_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int LINES  = 4,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode_step_4,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              flush,
  output logic              stall,
  output logic [WIDTH-1:0]  rdata,
  output logic              rdata_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output cache_state_e      dbg_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  // Handshake: mem_req/mem_we/mem_addr/mem_wdata come only from registered
  // state, so they hold steady until the cycle mem_ack is sampled high; an
  // ack outside REFILL/WRITE is never looked at.

  cache_state_e      state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0]  req_wdata_q, req_wdata_d;
  logic [WIDTH-1:0]  rdata_d;
  logic              rdata_valid_d;

  logic              is_lw, is_sw;
  logic [ADDR_W-1:0] lk_addr;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  lk_index;
  logic [OFF_W-1:0]  lk_off;
  logic              hit;
  logic [WIDTH-1:0]  rd_word;

  logic              word_we, line_inval, line_fill, flush_all;
  logic [OFF_W-1:0]  wr_offset;
  logic [WIDTH-1:0]  wr_word;

  assign is_lw = req_valid && (opcode_step_4 == OP_LW);
  assign is_sw = req_valid && (opcode_step_4 == OP_SW);

  // Look up the incoming address while idle, the latched one while busy.
  assign lk_addr  = (state_q == IDLE) ? addr : req_addr_q;
  assign lk_tag   = lk_addr[ADDR_W-1 -: TAG_W];
  assign lk_index = lk_addr[OFF_W +: IDX_W];
  assign lk_off   = lk_addr[OFF_W-1:0];

  assign dbg_state = state_q;

  cache_array #(
    .WIDTH (WIDTH),
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (lk_index),
    .rd_offset  (lk_off),
    .rd_tag     (lk_tag),
    .hit        (hit),
    .rd_word    (rd_word),
    .word_we    (word_we),
    .wr_index   (lk_index),
    .wr_offset  (wr_offset),
    .wr_word    (wr_word),
    .line_inval (line_inval),
    .line_fill  (line_fill),
    .fill_tag   (lk_tag),
    .flush_all  (flush_all)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata       <= rdata_d;
      rdata_valid <= rdata_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    rdata_d       = rdata;
    rdata_valid_d = 1'b0;
    word_we       = 1'b0;
    wr_offset     = cnt_q;
    wr_word       = mem_rdata;
    line_inval    = 1'b0;
    line_fill     = 1'b0;
    flush_all     = 1'b0;
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state_q)
      IDLE: begin
        if (is_lw && hit) begin
          rdata_d       = rd_word;
          rdata_valid_d = 1'b1;
        end else if (is_lw) begin
          // Drop the victim's valid bit up front so the line never looks
          // valid while only part of it has been refilled.
          stall      = 1'b1;
          req_addr_d = addr;
          cnt_d      = '0;
          line_inval = 1'b1;
          state_d    = REFILL;
        end else if (is_sw) begin
          stall       = 1'b1;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          state_d     = WRITE;
        end else if (!req_valid && flush) begin
          flush_all = 1'b1;
        end
      end

      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {lk_tag, lk_index, cnt_q};
        if (mem_ack) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == lk_off) begin
            rdata_d = mem_rdata;
          end
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            line_fill     = 1'b1;
            rdata_valid_d = 1'b1;
            cnt_d         = '0;
            state_d       = RESP;
          end
        end
      end

      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr_q;
        mem_wdata = req_wdata_q;
        if (mem_ack) begin
          state_d = IDLE;
          if (hit) begin
            word_we   = 1'b1;
            wr_offset = lk_off;
            wr_word   = req_wdata_q;
          end
        end
      end

      RESP: begin
        stall   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
